// File: rtl/tcdm_if.sv
// tcdm_if: TCDM request/grant bus with single-cycle read response
interface tcdm_if;
  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] data;
  logic [31:0] r_data;
  modport master (output req, add, wen, be, data, input gnt, r_data);
  modport slave  (input req, add, wen, be, data, output gnt, r_data);
endinterface

// File: rtl/tcdm_fill_check_master.sv
// tcdm_fill_check_master: fills a TCDM region with a pattern or reads it back and counts mismatches
module tcdm_fill_check_master #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic                 incr_i,
  input  logic [31:0]          base_addr_i,
  input  logic [CNT_WIDTH-1:0] num_words_i,
  input  logic [31:0]          pattern_i,
  tcdm_if.master               tcdm,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  output logic [31:0]          first_err_addr_o
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  logic [1:0]           state_q, state_d;
  logic                 mode_q, mode_d, incr_q, incr_d;
  logic [31:0]          base_q, base_d, pat_q, pat_d;
  logic [CNT_WIDTH-1:0] num_q, num_d, idx_q, idx_d;
  logic                 pend_q, pend_d;
  logic [31:0]          exp_q, exp_d, exp_add_q, exp_add_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          fea_q, fea_d;
  logic                 run, fire, last, mism;
  logic [31:0]          idx_w, add, wdata;
  assign run   = state_q == RUN;
  assign fire  = run && tcdm.gnt;
  assign last  = idx_q == num_q - CNT_WIDTH'(1);
  assign idx_w = 32'(idx_q);
  assign add   = base_q + (idx_w << 2);
  assign wdata = incr_q ? pat_q + idx_w : pat_q;
  // The one-entry pipeline holds what the previous granted read should return
  assign mism  = pend_q && tcdm.r_data != exp_q;
  assign tcdm.req  = run;
  assign tcdm.add  = run ? add : 32'h0;
  assign tcdm.wen  = run ? mode_q : 1'b1;
  assign tcdm.be   = run ? 4'hF : 4'h0;
  assign tcdm.data = run && !mode_q ? wdata : 32'h0;
  assign busy_o           = state_q != IDLE;
  assign done_o           = state_q == DONE;
  assign err_o            = err_q;
  assign err_cnt_o        = cnt_q;
  assign first_err_addr_o = fea_q;
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    incr_d    = incr_q;
    base_d    = base_q;
    pat_d     = pat_q;
    num_d     = num_q;
    idx_d     = fire ? idx_q + CNT_WIDTH'(1) : idx_q;
    pend_d    = fire && mode_q;
    exp_d     = fire ? wdata : exp_q;
    exp_add_d = fire ? add : exp_add_q;
    err_d     = err_q || mism;
    cnt_d     = mism && !(&cnt_q) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    fea_d     = mism && cnt_q == '0 ? exp_add_q : fea_q;
    case (state_q)
      IDLE: if (start_i) begin
        mode_d  = mode_i;
        incr_d  = incr_i;
        base_d  = base_addr_i;
        pat_d   = pattern_i;
        num_d   = num_words_i;
        idx_d   = '0;
        err_d   = 1'b0;
        cnt_d   = '0;
        fea_d   = 32'h0;
        state_d = num_words_i == '0 ? DONE : RUN;
      end
      RUN:     state_d = fire && last ? (mode_q ? DRAIN : DONE) : RUN;
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      incr_q    <= 1'b0;
      base_q    <= 32'h0;
      pat_q     <= 32'h0;
      num_q     <= '0;
      idx_q     <= '0;
      pend_q    <= 1'b0;
      exp_q     <= 32'h0;
      exp_add_q <= 32'h0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      fea_q     <= 32'h0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      incr_q    <= incr_d;
      base_q    <= base_d;
      pat_q     <= pat_d;
      num_q     <= num_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      exp_q     <= exp_d;
      exp_add_q <= exp_add_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      fea_q     <= fea_d;
    end
  end
endmodule

// File: tb/tb_tcdm_fill_check_master.sv
// tb_tcdm_fill_check_master: directed tests with a small TCDM memory responder
module tb_tcdm_fill_check_master;
  logic clk = 0, rst_n = 0, start = 0, mode = 0, incr = 0;
  logic [31:0] base = 0, pat = 0;
  logic [15:0] num = 0;
  logic busy, done, err;
  logic [15:0] cnt;
  logic [31:0] fea;
  tcdm_if bus();
  tcdm_fill_check_master #(.CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode), .incr_i(incr),
    .base_addr_i(base), .num_words_i(num), .pattern_i(pat), .tcdm(bus),
    .busy_o(busy), .done_o(done), .err_o(err), .err_cnt_o(cnt), .first_err_addr_o(fea));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [31:0] mem [16];
  logic [31:0] corrupt_addr = 32'h1;
  always @(posedge clk)
    if (bus.req && bus.gnt) begin
      if (!bus.wen) mem[bus.add[5:2]] <= bus.data;
      else bus.r_data <= bus.add == corrupt_addr ? 32'hFF : mem[bus.add[5:2]];
    end
  int checks = 0, errors = 0;
  logic [31:0] ga [16], gd [16];
  logic gw [16];
  int gc [16];
  int ngnt, done_cyc, last_cyc, start_cyc, busy_cnt;
  bit stable_ok, be_ok;

  task automatic run_op(input logic m, input logic inc, input logic [31:0] b,
                        input logic [15:0] n, input logic [31:0] p, input bit stall);
    logic [31:0] pa, pd;
    bit pstall = 0;
    ngnt = 0; done_cyc = -1; last_cyc = -1; busy_cnt = 0; stable_ok = 1; be_ok = 1;
    @(negedge clk);
    mode = m; incr = inc; base = b; num = n; pat = p; start = 1; start_cyc = cyc;
    @(negedge clk);
    start = 0;
    for (int k = 0; k < 64; k++) begin
      if (busy) busy_cnt++;
      if (done) begin done_cyc = cyc; break; end
      if (pstall && (!bus.req || bus.add !== pa || bus.data !== pd)) stable_ok = 0;
      if (bus.req && bus.be !== 4'hF) be_ok = 0;
      bus.gnt = stall ? logic'(k % 2) : 1'b1;
      pstall = bus.req && !bus.gnt; pa = bus.add; pd = bus.data;
      if (bus.req && bus.gnt && ngnt < 16) begin
        ga[ngnt] = bus.add; gd[ngnt] = bus.data; gw[ngnt] = bus.wen; gc[ngnt] = cyc;
        last_cyc = cyc; ngnt++;
      end
      @(negedge clk);
    end
    bus.gnt = 0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL rst_req got %0h want 0", bus.req); end
    checks++; if (bus.add !== 32'h0 || bus.data !== 32'h0) begin errors++; $display("FAIL rst_add_data got %0h/%0h want 0/0", bus.add, bus.data); end
    checks++; if (bus.be !== 4'h0 || bus.wen !== 1'b1) begin errors++; $display("FAIL rst_be_wen got %0h/%0h want 0/1", bus.be, bus.wen); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_busy_done got %0h/%0h want 0/0", busy, done); end
    checks++; if (err !== 1'b0 || cnt !== 16'h0 || fea !== 32'h0) begin errors++; $display("FAIL rst_err got %0h/%0h/%0h want 0/0/0", err, cnt, fea); end
    rst_n = 1;
  endtask

  task automatic test_fill;
    run_op(0, 1, 32'h100, 4, 32'hA0, 0);
    checks++; if (ngnt !== 4) begin errors++; $display("FAIL fill_count got %0d want 4", ngnt); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (ga[i] !== 32'h100 + 4 * i || gd[i] !== 32'hA0 + i || gw[i] !== 1'b0) begin
        errors++; $display("FAIL fill_word%0d got %0h/%0h/%0h want %0h/%0h/0", i, ga[i], gd[i], gw[i], 32'h100 + 4 * i, 32'hA0 + i);
      end
    end
    checks++; if (gc[3] - gc[0] !== 3) begin errors++; $display("FAIL fill_b2b got %0d want 3", gc[3] - gc[0]); end
    checks++; if (done_cyc - last_cyc !== 1) begin errors++; $display("FAIL fill_done_lat got %0d want 1", done_cyc - last_cyc); end
    checks++; if (!be_ok) begin errors++; $display("FAIL fill_be got 0 want 1"); end
    checks++; if (err !== 1'b0 || cnt !== 16'h0) begin errors++; $display("FAIL fill_err got %0h/%0h want 0/0", err, cnt); end
  endtask

  task automatic test_check_stall;
    run_op(1, 1, 32'h100, 4, 32'hA0, 1);
    checks++; if (ngnt !== 4) begin errors++; $display("FAIL chk_count got %0d want 4", ngnt); end
    checks++; if (!stable_ok) begin errors++; $display("FAIL chk_stable got 0 want 1"); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (ga[i] !== 32'h100 + 4 * i || gd[i] !== 32'h0 || gw[i] !== 1'b1) begin
        errors++; $display("FAIL chk_word%0d got %0h/%0h/%0h want %0h/0/1", i, ga[i], gd[i], gw[i], 32'h100 + 4 * i);
      end
    end
    checks++; if (done_cyc - last_cyc !== 2) begin errors++; $display("FAIL chk_done_lat got %0d want 2", done_cyc - last_cyc); end
    checks++; if (err !== 1'b0 || cnt !== 16'h0) begin errors++; $display("FAIL chk_err got %0h/%0h want 0/0", err, cnt); end
  endtask

  task automatic test_check_err;
    corrupt_addr = 32'h108;
    run_op(1, 1, 32'h100, 4, 32'hA0, 0);
    corrupt_addr = 32'h1;
    checks++; if (err !== 1'b1 || cnt !== 16'd1 || fea !== 32'h108) begin errors++; $display("FAIL err_one got %0h/%0h/%0h want 1/1/108", err, cnt, fea); end
    repeat (2) @(negedge clk);
    checks++; if (err !== 1'b1 || cnt !== 16'd1 || fea !== 32'h108 || busy !== 1'b0) begin errors++; $display("FAIL err_hold got %0h/%0h/%0h want 1/1/108", err, cnt, fea); end
    run_op(1, 0, 32'h100, 4, 32'hA0, 0);
    checks++; if (err !== 1'b1 || cnt !== 16'd3 || fea !== 32'h104) begin errors++; $display("FAIL err_multi got %0h/%0h/%0h want 1/3/104", err, cnt, fea); end
    run_op(0, 1, 32'h100, 4, 32'hA0, 0);
    checks++; if (err !== 1'b0 || cnt !== 16'h0 || fea !== 32'h0) begin errors++; $display("FAIL err_clear got %0h/%0h/%0h want 0/0/0", err, cnt, fea); end
  endtask

  task automatic test_zero;
    run_op(0, 0, 32'h200, 0, 32'h5, 0);
    checks++; if (ngnt !== 0) begin errors++; $display("FAIL zero_req got %0d want 0", ngnt); end
    checks++; if (busy_cnt !== 1) begin errors++; $display("FAIL zero_busy got %0d want 1", busy_cnt); end
    checks++; if (done_cyc - start_cyc !== 1) begin errors++; $display("FAIL zero_done got %0d want 1", done_cyc - start_cyc); end
  endtask

  task automatic test_wrap;
    logic [31:0] ea [4];
    logic [31:0] ed [4];
    ea = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h4};
    ed = '{32'hFFFFFFFF, 32'h0, 32'h1, 32'h2};
    run_op(0, 1, 32'hFFFFFFF8, 4, 32'hFFFFFFFF, 0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (ga[i] !== ea[i] || gd[i] !== ed[i]) begin
        errors++; $display("FAIL wrap_word%0d got %0h/%0h want %0h/%0h", i, ga[i], gd[i], ea[i], ed[i]);
      end
    end
    run_op(1, 1, 32'hFFFFFFF8, 4, 32'hFFFFFFFF, 1);
    checks++; if (err !== 1'b0 || cnt !== 16'h0 || ngnt !== 4) begin errors++; $display("FAIL wrap_chk got %0h/%0h/%0d want 0/0/4", err, cnt, ngnt); end
  endtask

  task automatic test_start_in_done;
    @(negedge clk);
    num = 0; mode = 0; start = 1;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL sid_done got %0h want 1", done); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL sid_ignore got %0h/%0h want 0/0", busy, done); end
    start = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit seen_done = 0;
    run_op(0, 1, 32'h100, 4, 32'hA0, 0);
    corrupt_addr = 32'h100;
    @(negedge clk);
    mode = 1; incr = 1; base = 32'h100; num = 4; pat = 32'hA0; start = 1; bus.gnt = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL rm_running got %0h want 1", bus.req); end
    rst_n = 0;
    @(negedge clk);
    checks++; if (bus.req !== 1'b0 || busy !== 1'b0 || cnt !== 16'h0 || done !== 1'b0) begin
      errors++; $display("FAIL rm_abort got %0h/%0h/%0h/%0h want 0/0/0/0", bus.req, busy, cnt, done);
    end
    rst_n = 1; bus.gnt = 0; corrupt_addr = 32'h1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    checks++; if (seen_done || cnt !== 16'h0 || err !== 1'b0) begin errors++; $display("FAIL rm_nodone got %0h/%0h/%0h want 0/0/0", seen_done, cnt, err); end
  endtask

  initial begin
    bus.gnt = 0;
    test_reset;
    test_fill;
    test_check_stall;
    test_check_err;
    test_zero;
    test_wrap;
    test_start_in_done;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
